// File: rtl/sync_fifo_prog_if.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_prog_if
// Description : Handshake / status bundle for the programmable synchronous
//               FIFO. The master modport is the producer/consumer side, the
//               slave modport is the FIFO itself.
//               Producer/consumer -> FIFO : flush, data_in, wr_en, rd_en,
//                                           af_level, ae_level
//               FIFO -> producer/consumer : data_out, rd_valid, wr_ack,
//                                           overflow, underflow, full, empty,
//                                           almostfull, almostempty, count
// Revision    : 1.0 - initial release
// ============================================================================
interface sync_fifo_prog_if #(
    parameter int FIFO_WIDTH = 16,
    parameter int CNT_W      = 4
);
    logic                  flush;
    logic [FIFO_WIDTH-1:0] data_in;
    logic                  wr_en;
    logic                  rd_en;
    logic [CNT_W-1:0]      af_level;
    logic [CNT_W-1:0]      ae_level;

    logic [FIFO_WIDTH-1:0] data_out;
    logic                  rd_valid;
    logic                  wr_ack;
    logic                  overflow;
    logic                  underflow;
    logic                  full;
    logic                  empty;
    logic                  almostfull;
    logic                  almostempty;
    logic [CNT_W-1:0]      count;

    modport master (
        output flush, data_in, wr_en, rd_en, af_level, ae_level,
        input  data_out, rd_valid, wr_ack, overflow, underflow,
               full, empty, almostfull, almostempty, count
    );

    modport slave (
        input  flush, data_in, wr_en, rd_en, af_level, ae_level,
        output data_out, rd_valid, wr_ack, overflow, underflow,
               full, empty, almostfull, almostempty, count
    );
endinterface
`default_nettype wire

// File: rtl/sync_fifo_prog.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_prog
// Description : Single-clock FIFO with arbitrary (non power-of-two) depth,
//               runtime-programmable almost-full / almost-empty thresholds,
//               occupancy count, synchronous flush and a selectable
//               first-word-fall-through read mode.
// Ports       : clk  - clock, all state changes on the rising edge
//               rst  - synchronous active-high reset
//               bus  - sync_fifo_prog_if.slave
//                      in : flush, data_in, wr_en, rd_en, af_level, ae_level
//                      out: data_out, rd_valid, wr_ack, overflow, underflow,
//                           full, empty, almostfull, almostempty, count
// Parameters  : FIFO_WIDTH - data word width
//               FIFO_DEPTH - number of storage entries (>= 2)
//               FWFT       - 0: registered read, 1: first-word-fall-through
//               CNT_W      - derived width of count / thresholds
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_prog #(
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int FWFT       = 0,
    parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input wire              clk,
    input wire              rst,
    sync_fifo_prog_if.slave bus
);

    // Pointer width covers indices 0..FIFO_DEPTH-1; wrap is explicit so
    // non power-of-two depths never touch the unused index codes.
    localparam int                 c_PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [c_PTR_W-1:0] c_LAST_PTR = c_PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0]   c_FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]   c_CNT_ONE  = CNT_W'(1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [FIFO_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic                  r_wr_ack;
    logic                  r_overflow;
    logic                  r_underflow;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_write_ok;
    logic                  w_read_ok;
    logic                  w_clear;

    function automatic logic [c_PTR_W-1:0] f_next_ptr(input logic [c_PTR_W-1:0] ptr);
        return (ptr == c_LAST_PTR) ? '0 : ptr + c_PTR_W'(1);
    endfunction

    // ------------------------------------------------------------------------
    // Status, decided from the occupancy at the start of the cycle
    // ------------------------------------------------------------------------
    assign w_full  = (r_count == c_FULL_CNT);
    assign w_empty = (r_count == '0);

    // A read in the same cycle frees the slot the write needs, so a full FIFO
    // still accepts a write when it is also being read (pass-through).
    assign w_write_ok = bus.wr_en & (~w_full | bus.rd_en);
    assign w_read_ok  = bus.rd_en & ~w_empty;

    // Reset and flush clear the same bookkeeping; they differ only in what
    // happens to the registered read data.
    assign w_clear = rst | bus.flush;

    // ------------------------------------------------------------------------
    // Pointers, occupancy and one-cycle handshake flags
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_wr_ack    <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_write_ok) begin
                r_wr_ptr <= f_next_ptr(r_wr_ptr);
            end
            if (w_read_ok) begin
                r_rd_ptr <= f_next_ptr(r_rd_ptr);
            end

            case ({w_write_ok, w_read_ok})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase

            r_wr_ack    <= w_write_ok;
            r_overflow  <= bus.wr_en & w_full & ~bus.rd_en;
            r_underflow <= bus.rd_en & w_empty;
        end
    end

    // ------------------------------------------------------------------------
    // Storage: never reset or cleared; stale words become unreachable once
    // the pointers and count are cleared.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!w_clear && w_write_ok) begin
            r_mem[r_wr_ptr] <= bus.data_in;
        end
    end

    // ------------------------------------------------------------------------
    // Read data path
    // ------------------------------------------------------------------------
    if (FWFT != 0) begin : g_fwft
        // Head word is always on display; rd_en only pops it. The output is
        // forced to zero while empty so it never shows a discarded word.
        assign bus.data_out = w_empty ? '0 : r_mem[r_rd_ptr];
        assign bus.rd_valid = ~w_empty;
    end else begin : g_std
        logic [FIFO_WIDTH-1:0] r_data_out;
        logic                  r_rd_valid;

        // On a full pass-through the write and read hit the same slot; the
        // non-blocking read returns the old (oldest) word as required.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_data_out <= '0;
                r_rd_valid <= 1'b0;
            end else if (bus.flush) begin
                r_rd_valid <= 1'b0;
            end else begin
                r_rd_valid <= w_read_ok;
                if (w_read_ok) begin
                    r_data_out <= r_mem[r_rd_ptr];
                end
            end
        end

        assign bus.data_out = r_data_out;
        assign bus.rd_valid = r_rd_valid;
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.wr_ack      = r_wr_ack;
    assign bus.overflow    = r_overflow;
    assign bus.underflow   = r_underflow;
    assign bus.full        = w_full;
    assign bus.empty       = w_empty;
    assign bus.almostfull  = (r_count >= bus.af_level);
    assign bus.almostempty = (r_count <= bus.ae_level);
    assign bus.count       = r_count;

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_prog.sv
`default_nettype none
// ============================================================================
// Module      : tb_sync_fifo_prog
// Description : Bench for sync_fifo_prog. Three instances:
//               0 - depth 8, standard read
//               1 - depth 5, standard read (pointer wrap on odd depth)
//               2 - depth 8, first-word-fall-through
//               A queue-based model is compared with every output on every
//               falling edge; directed literal checks pin the model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_fifo_prog;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_s   [3];
    logic        flush_s [3];
    logic        wr_s    [3];
    logic        rd_s    [3];
    logic [15:0] din_s   [3];
    logic [3:0]  af_s    [3];
    logic [3:0]  ae_s    [3];

    logic [15:0] dout_o  [3];
    logic        rdv_o   [3];
    logic        ack_o   [3];
    logic        ovf_o   [3];
    logic        udf_o   [3];
    logic        full_o  [3];
    logic        empty_o [3];
    logic        af_o    [3];
    logic        ae_o    [3];
    logic [3:0]  cnt_o   [3];

    sync_fifo_prog_if #(.FIFO_WIDTH(16), .CNT_W(4)) bus0 ();
    sync_fifo_prog_if #(.FIFO_WIDTH(16), .CNT_W(3)) bus1 ();
    sync_fifo_prog_if #(.FIFO_WIDTH(16), .CNT_W(4)) bus2 ();

    sync_fifo_prog #(.FIFO_WIDTH(16), .FIFO_DEPTH(8), .FWFT(0)) u_dut0 (.clk(clk), .rst(rst_s[0]), .bus(bus0));
    sync_fifo_prog #(.FIFO_WIDTH(16), .FIFO_DEPTH(5), .FWFT(0)) u_dut1 (.clk(clk), .rst(rst_s[1]), .bus(bus1));
    sync_fifo_prog #(.FIFO_WIDTH(16), .FIFO_DEPTH(8), .FWFT(1)) u_dut2 (.clk(clk), .rst(rst_s[2]), .bus(bus2));

    assign bus0.flush    = flush_s[0];
    assign bus0.data_in  = din_s[0];
    assign bus0.wr_en    = wr_s[0];
    assign bus0.rd_en    = rd_s[0];
    assign bus0.af_level = af_s[0];
    assign bus0.ae_level = ae_s[0];
    assign dout_o[0]     = bus0.data_out;
    assign rdv_o[0]      = bus0.rd_valid;
    assign ack_o[0]      = bus0.wr_ack;
    assign ovf_o[0]      = bus0.overflow;
    assign udf_o[0]      = bus0.underflow;
    assign full_o[0]     = bus0.full;
    assign empty_o[0]    = bus0.empty;
    assign af_o[0]       = bus0.almostfull;
    assign ae_o[0]       = bus0.almostempty;
    assign cnt_o[0]      = bus0.count;

    assign bus1.flush    = flush_s[1];
    assign bus1.data_in  = din_s[1];
    assign bus1.wr_en    = wr_s[1];
    assign bus1.rd_en    = rd_s[1];
    assign bus1.af_level = af_s[1][2:0];
    assign bus1.ae_level = ae_s[1][2:0];
    assign dout_o[1]     = bus1.data_out;
    assign rdv_o[1]      = bus1.rd_valid;
    assign ack_o[1]      = bus1.wr_ack;
    assign ovf_o[1]      = bus1.overflow;
    assign udf_o[1]      = bus1.underflow;
    assign full_o[1]     = bus1.full;
    assign empty_o[1]    = bus1.empty;
    assign af_o[1]       = bus1.almostfull;
    assign ae_o[1]       = bus1.almostempty;
    assign cnt_o[1]      = {1'b0, bus1.count};

    assign bus2.flush    = flush_s[2];
    assign bus2.data_in  = din_s[2];
    assign bus2.wr_en    = wr_s[2];
    assign bus2.rd_en    = rd_s[2];
    assign bus2.af_level = af_s[2];
    assign bus2.ae_level = ae_s[2];
    assign dout_o[2]     = bus2.data_out;
    assign rdv_o[2]      = bus2.rd_valid;
    assign ack_o[2]      = bus2.wr_ack;
    assign ovf_o[2]      = bus2.overflow;
    assign udf_o[2]      = bus2.underflow;
    assign full_o[2]     = bus2.full;
    assign empty_o[2]    = bus2.empty;
    assign af_o[2]       = bus2.almostfull;
    assign ae_o[2]       = bus2.almostempty;
    assign cnt_o[2]      = bus2.count;

    // ------------------------------------------------------------------------
    // Reference model: contents as a queue, handshake flags as plain bits
    // ------------------------------------------------------------------------
    logic [15:0] mq     [3][$];
    logic [15:0] m_data [3];
    bit          m_rdv  [3];
    bit          m_ack  [3];
    bit          m_ovf  [3];
    bit          m_udf  [3];

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    function automatic int depth_of(input int k);
        return (k == 1) ? 5 : 8;
    endfunction

    function automatic bit fwft_of(input int k);
        return (k == 2);
    endfunction

    task automatic cmp(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s[%0d] at %0t: got 0x%0h, expected 0x%0h", name, k, $time, act, exp);
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < 3; k++) begin
            int n;
            bit wok;
            bit rok;
            n = mq[k].size();
            if (rst_s[k]) begin
                mq[k].delete();
                m_data[k] = '0;
                m_rdv[k]  = 1'b0;
                m_ack[k]  = 1'b0;
                m_ovf[k]  = 1'b0;
                m_udf[k]  = 1'b0;
            end else if (flush_s[k]) begin
                mq[k].delete();
                m_rdv[k] = 1'b0;
                m_ack[k] = 1'b0;
                m_ovf[k] = 1'b0;
                m_udf[k] = 1'b0;
            end else begin
                wok = wr_s[k] && ((n < depth_of(k)) || rd_s[k]);
                rok = rd_s[k] && (n > 0);
                if (rok) begin
                    m_data[k] = mq[k].pop_front();
                end
                if (wok) begin
                    mq[k].push_back(din_s[k]);
                end
                m_rdv[k] = rok;
                m_ack[k] = wok;
                m_ovf[k] = wr_s[k] && (n == depth_of(k)) && !rd_s[k];
                m_udf[k] = rd_s[k] && (n == 0);
            end
        end
    endtask

    task automatic check_outputs(input int k);
        int n;
        n = mq[k].size();
        cmp("count",       k, 32'(cnt_o[k]), n);
        cmp("full",        k, full_o[k],  n == depth_of(k));
        cmp("empty",       k, empty_o[k], n == 0);
        cmp("almostfull",  k, af_o[k],    n >= int'(af_s[k]));
        cmp("almostempty", k, ae_o[k],    n <= int'(ae_s[k]));
        cmp("wr_ack",      k, ack_o[k],   m_ack[k]);
        cmp("overflow",    k, ovf_o[k],   m_ovf[k]);
        cmp("underflow",   k, udf_o[k],   m_udf[k]);
        if (fwft_of(k)) begin
            cmp("rd_valid", k, rdv_o[k], n > 0);
            if (n > 0) begin
                cmp("data_out", k, dout_o[k], mq[k][0]);
            end
        end else begin
            cmp("rd_valid", k, rdv_o[k],  m_rdv[k]);
            cmp("data_out", k, dout_o[k], m_data[k]);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                for (int k = 0; k < 3; k++) begin
                    check_outputs(k);
                end
            end
        end
    end

    // One clock: model sees the same pre-edge inputs as the DUTs.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // ------------------------------------------------------------------------
    // Directed stimulus with literal expectations
    // ------------------------------------------------------------------------
    initial begin
        for (int k = 0; k < 3; k++) begin
            rst_s[k]   = 1'b1;
            flush_s[k] = 1'b0;
            wr_s[k]    = 1'b0;
            rd_s[k]    = 1'b0;
            din_s[k]   = '0;
        end
        af_s[0] = 4'd0; ae_s[0] = 4'd2;
        af_s[1] = 4'd4; ae_s[1] = 4'd1;
        af_s[2] = 4'd3; ae_s[2] = 4'd1;
        step();
        step();
        for (int k = 0; k < 3; k++) rst_s[k] = 1'b0;
        chk_en = 1'b1;

        // Reset state of instance 0 (af_level=0 -> almostfull)
        cmp("rst_count",    0, 32'(cnt_o[0]), 0);
        cmp("rst_full",     0, full_o[0],  0);
        cmp("rst_empty",    0, empty_o[0], 1);
        cmp("rst_af",       0, af_o[0],    1);
        cmp("rst_ae",       0, ae_o[0],    1);
        cmp("rst_wr_ack",   0, ack_o[0],   0);
        cmp("rst_rd_valid", 0, rdv_o[0],   0);
        cmp("rst_data_out", 0, dout_o[0],  0);
        af_s[0] = 4'd8;
        ae_s[0] = 4'd0;

        // Fill to full, then overflow
        for (int i = 1; i <= 8; i++) begin
            wr_s[0] = 1'b1; din_s[0] = 16'(i);
            step();
            cmp("fill_ack",   0, ack_o[0], 1);
            cmp("fill_count", 0, 32'(cnt_o[0]), i);
        end
        wr_s[0] = 1'b0;
        cmp("fill_full", 0, full_o[0], 1);
        wr_s[0] = 1'b1; din_s[0] = 16'h0009;
        step();
        wr_s[0] = 1'b0;
        cmp("ovf_flag",  0, ovf_o[0], 1);
        cmp("ovf_count", 0, 32'(cnt_o[0]), 8);

        // Drain in order, then underflow
        for (int i = 1; i <= 8; i++) begin
            rd_s[0] = 1'b1;
            step();
            cmp("drain_valid", 0, rdv_o[0], 1);
            cmp("drain_data",  0, dout_o[0], i);
        end
        rd_s[0] = 1'b0;
        cmp("drain_empty", 0, empty_o[0], 1);
        rd_s[0] = 1'b1;
        step();
        rd_s[0] = 1'b0;
        cmp("udf_flag",  0, udf_o[0], 1);
        cmp("udf_valid", 0, rdv_o[0], 0);

        // Pass-through while full
        for (int i = 1; i <= 8; i++) begin
            wr_s[0] = 1'b1; din_s[0] = 16'(i);
            step();
        end
        wr_s[0] = 1'b1; rd_s[0] = 1'b1; din_s[0] = 16'hAAAA;
        step();
        wr_s[0] = 1'b0; rd_s[0] = 1'b0;
        cmp("pt_ack",   0, ack_o[0], 1);
        cmp("pt_data",  0, dout_o[0], 16'h0001);
        cmp("pt_count", 0, 32'(cnt_o[0]), 8);
        for (int i = 2; i <= 9; i++) begin
            rd_s[0] = 1'b1;
            step();
            cmp("pt_drain", 0, dout_o[0], (i == 9) ? 16'hAAAA : 16'(i));
        end
        rd_s[0] = 1'b0;

        // Both on empty: write accepted, read rejected
        wr_s[0] = 1'b1; rd_s[0] = 1'b1; din_s[0] = 16'h5555;
        step();
        wr_s[0] = 1'b0; rd_s[0] = 1'b0;
        cmp("be_ack",   0, ack_o[0], 1);
        cmp("be_udf",   0, udf_o[0], 1);
        cmp("be_count", 0, 32'(cnt_o[0]), 1);
        rd_s[0] = 1'b1;
        step();
        rd_s[0] = 1'b0;
        cmp("be_data", 0, dout_o[0], 16'h5555);

        // Thresholds
        af_s[0] = 4'd6; ae_s[0] = 4'd2;
        for (int i = 1; i <= 6; i++) begin
            wr_s[0] = 1'b1; din_s[0] = 16'h0100 + 16'(i);
            step();
            cmp("af_rise", 0, af_o[0], i >= 6);
        end
        wr_s[0] = 1'b0;
        af_s[0] = 4'd7;
        #1;
        cmp("af_level_change", 0, af_o[0], 0);
        for (int j = 1; j <= 4; j++) begin
            rd_s[0] = 1'b1;
            step();
            cmp("ae_rise", 0, ae_o[0], (6 - j) <= 2);
        end
        rd_s[0] = 1'b0;

        // Flush beats a concurrent write
        wr_s[0] = 1'b1; din_s[0] = 16'h0777; flush_s[0] = 1'b1;
        step();
        wr_s[0] = 1'b0; flush_s[0] = 1'b0;
        cmp("flush_count", 0, 32'(cnt_o[0]), 0);
        cmp("flush_empty", 0, empty_o[0], 1);
        cmp("flush_ack",   0, ack_o[0], 0);

        // Depth 5: write 5, read 3, write 3 (wrap), read all
        for (int i = 1; i <= 5; i++) begin
            wr_s[1] = 1'b1; din_s[1] = 16'h0B00 + 16'(i);
            step();
        end
        wr_s[1] = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            rd_s[1] = 1'b1;
            step();
            cmp("d5_read", 1, dout_o[1], 16'h0B00 + 16'(i));
        end
        rd_s[1] = 1'b0;
        for (int i = 6; i <= 8; i++) begin
            wr_s[1] = 1'b1; din_s[1] = 16'h0B00 + 16'(i);
            step();
        end
        wr_s[1] = 1'b0;
        cmp("d5_count", 1, 32'(cnt_o[1]), 5);
        cmp("d5_full",  1, full_o[1], 1);
        for (int i = 4; i <= 8; i++) begin
            rd_s[1] = 1'b1;
            step();
            cmp("d5_wrap_read", 1, dout_o[1], 16'h0B00 + 16'(i));
        end
        rd_s[1] = 1'b0;

        // FWFT: visible one cycle after the write, pop, flush, reset
        wr_s[2] = 1'b1; din_s[2] = 16'h1234;
        step();
        wr_s[2] = 1'b0;
        cmp("fwft_data",  2, dout_o[2], 16'h1234);
        cmp("fwft_valid", 2, rdv_o[2], 1);
        for (int i = 2; i <= 4; i++) begin
            wr_s[2] = 1'b1; din_s[2] = 16'(i) * 16'h1111;
            step();
        end
        wr_s[2] = 1'b0;
        rd_s[2] = 1'b1;
        step();
        rd_s[2] = 1'b0;
        cmp("fwft_pop", 2, dout_o[2], 16'h2222);
        wr_s[2] = 1'b1; din_s[2] = 16'h5555;
        step();
        cmp("fwft_count4", 2, 32'(cnt_o[2]), 4);
        din_s[2] = 16'h6666; flush_s[2] = 1'b1;
        step();
        wr_s[2] = 1'b0; flush_s[2] = 1'b0;
        cmp("fwft_flush_count", 2, 32'(cnt_o[2]), 0);
        cmp("fwft_flush_empty", 2, empty_o[2], 1);
        cmp("fwft_flush_ack",   2, ack_o[2], 0);
        for (int i = 7; i <= 9; i++) begin
            wr_s[2] = 1'b1; din_s[2] = 16'(i) * 16'h1111;
            step();
        end
        wr_s[2] = 1'b0;
        cmp("fwft_count3", 2, 32'(cnt_o[2]), 3);
        rst_s[2] = 1'b1;
        step();
        rst_s[2] = 1'b0;
        cmp("fwft_rst_count", 2, 32'(cnt_o[2]), 0);
        cmp("fwft_rst_empty", 2, empty_o[2], 1);
        cmp("fwft_rst_valid", 2, rdv_o[2], 0);
        cmp("fwft_rst_ack",   2, ack_o[2], 0);
        cmp("fwft_rst_data",  2, dout_o[2], 0);
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
